// File: rtl/linebuffer_kxk_if.sv
// Streaming handshake bundle for linebuffer_kxk: pixel input side and window output side.
interface linebuffer_kxk_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 3
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          pixel_in;
  logic                       in_sof;
  logic                       out_valid;
  logic                       out_ready;
  logic [K*K*DATA_W-1:0]      win_out;
  logic                       out_eol;
  logic                       out_eof;

  modport master (
    output in_valid, pixel_in, in_sof, out_ready,
    input  in_ready, out_valid, win_out, out_eol, out_eof
  );

  modport slave (
    input  in_valid, pixel_in, in_sof, out_ready,
    output in_ready, out_valid, win_out, out_eol, out_eof
  );
endinterface

// File: rtl/linebuffer_kxk.sv
// KxK sliding-window generator over a raster pixel stream using K-1 line memories.
// Optional framing-error detection is enabled by defining LINEBUFFER_SOF_CHECK_EN.
module linebuffer_kxk #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned K      = 3
) (
  input  logic             clk,
  input  logic             rst,
  linebuffer_kxk_if.slave  bus,
  output logic             err
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_KM1  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(K - 1);

  if (!(K == 3 || K == 5 || K == 7)) begin : g_bad_k
    $error("linebuffer_kxk: K must be 3, 5 or 7");
  end

  logic [COL_W-1:0]  r_col, w_col, w_col_nxt;
  logic [ROW_W-1:0]  r_row, w_row, w_row_nxt;
  logic              w_accept, w_line_end, w_qualify;
  logic [DATA_W-1:0] r_mem [K-1][IMG_W];
  logic [DATA_W-1:0] r_win [K][K];
  logic [DATA_W-1:0] w_col_new [K];
  logic              r_valid, r_eol, r_eof;

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // in_sof resynchronises: the pixel carrying it is always treated as (0,0)
  assign w_col      = bus.in_sof ? '0 : r_col;
  assign w_row      = bus.in_sof ? '0 : r_row;
  assign w_line_end = (w_col == COL_LAST);
  assign w_qualify  = (w_row >= ROW_KM1) && (w_col >= COL_KM1);

  always_comb begin
    w_col_nxt = w_col + 1'b1;
    w_row_nxt = w_row;
    if (w_line_end) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < K - 1; i++) begin
      w_col_new[i] = r_mem[i][w_col];
    end
    w_col_new[K-1] = bus.pixel_in;
  end

  // Line memories hold no reset; rows are rewritten before they reach a valid window
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int unsigned i = 0; i < K - 2; i++) begin
        r_mem[i][w_col] <= r_mem[i+1][w_col];
      end
      r_mem[K-2][w_col] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][K-1] <= w_col_new[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= w_qualify;
      r_eol   <= w_qualify && w_line_end;
      r_eof   <= w_qualify && w_line_end && (w_row == ROW_LAST);
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_eol   = r_eol;
  assign bus.out_eof   = r_eof;

  for (genvar gr = 0; gr < K; gr++) begin : g_row
    for (genvar gc = 0; gc < K; gc++) begin : g_col
      assign bus.win_out[(gr*K+gc)*DATA_W +: DATA_W] = r_win[gr][gc];
    end
  end

`ifdef LINEBUFFER_SOF_CHECK_EN
  logic r_started, r_err, w_at_origin;
  assign w_at_origin = (r_row == '0) && (r_col == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_started <= 1'b1;
      if ((bus.in_sof && !w_at_origin) || (!bus.in_sof && w_at_origin && r_started)) begin
        r_err <= 1'b1;
      end
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
